// File: rtl/fifo_drain.sv
// FIFO consumer stage: pops words, absorbs RAM read latency in a C=RD_LAT+1 entry skid buffer.
// Optional `FIFO_DRAIN_COUNT_EN` adds a 16-bit wrapping transfer counter output word_count.
module fifo_drain #(
  parameter int width  = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_data,
  output logic             fifo_read,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  localparam int C  = RD_LAT + 1;
  localparam int PW = $clog2(C);
  localparam int OW = $clog2(C + 1);

  logic [width-1:0]  mem [C];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [OW-1:0]     occ;
  logic [RD_LAT-1:0] inflight;
  logic [OW-1:0]     inflight_cnt;
  logic              capture;
  logic              transfer;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(C - 1)) ? '0 : p + PW'(1);
  endfunction

  assign capture   = inflight[RD_LAT-1];
  assign out_valid = (occ != '0);
  assign transfer  = out_valid && out_ready;
  assign out_data  = mem[head];

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + OW'(inflight[i]);
    end
  end

  // Count words already promised to the buffer so a pop never outruns free space.
  assign fifo_read = !reset && !fifo_empty &&
                     ((int'(occ) + int'(inflight_cnt) - int'(transfer)) < C);

  always_ff @(posedge clk) begin
    if (reset) begin
      occ      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
    end else begin
      inflight <= (inflight << 1) | RD_LAT'(fifo_read);
      if (capture) tail <= ptr_next(tail);
      if (transfer) head <= ptr_next(head);
      case ({capture, transfer})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && capture) mem[tail] <= fifo_data;
  end

`ifdef FIFO_DRAIN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) word_count <= '0;
    else if (transfer) word_count <= word_count + 16'd1;
  end
`endif

  assert property (@(posedge clk) disable iff (reset) capture |-> (occ != OW'(C)));

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: RD_LAT=1 and RD_LAT=2 instances, each fed by a behavioural FIFO.
module tb_fifo_drain;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RD_LAT=1 instance and its FIFO model
  logic       fe1, rd1, ov1, or1;
  logic [3:0] fd1, od1;
  logic [3:0] mem1 [256];
  logic [7:0] wp1, rp1;
  assign fe1 = (wp1 == rp1);
  always @(posedge clk) begin
    if (flush) rp1 <= wp1;
    else if (rd1) begin
      fd1 <= mem1[rp1];
      rp1 <= rp1 + 8'd1;
    end
  end

  // RD_LAT=2 instance and its FIFO model
  logic       fe2, rd2, ov2, or2;
  logic [3:0] fd2, od2, s2;
  logic [3:0] mem2 [256];
  logic [7:0] wp2, rp2;
  assign fe2 = (wp2 == rp2);
  always @(posedge clk) begin
    fd2 <= s2;
    if (flush) rp2 <= wp2;
    else if (rd2) begin
      s2  <= mem2[rp2];
      rp2 <= rp2 + 8'd1;
    end
  end

`ifdef FIFO_DRAIN_COUNT_EN
  logic [15:0] wc1, wc2;
`endif

  fifo_drain #(.width(4), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fe1), .fifo_data(fd1), .fifo_read(rd1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1)
`ifdef FIFO_DRAIN_COUNT_EN
    , .word_count(wc1)
`endif
  );

  fifo_drain #(.width(4), .RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fe2), .fifo_data(fd2), .fifo_read(rd2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2)
`ifdef FIFO_DRAIN_COUNT_EN
    , .word_count(wc2)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [3:0] v);
    mem1[wp1] = v;
    wp1 = wp1 + 8'd1;
  endtask

  task automatic push2(input logic [3:0] v);
    mem2[wp2] = v;
    wp2 = wp2 + 8'd1;
  endtask

  task automatic test_reset;
    or1 = 1'b1; or2 = 1'b0;
    tick; tick;
    flush = 1'b0;
    for (int v = 1; v <= 5; v++) push1(4'(v));
    for (int c = 0; c < 3; c++) begin
      tick; #1;
      checks++;
      if (rd1 !== 1'b0) begin errors++; $display("FAIL reset_rd cyc %0d: got %b want 0", c, rd1); end
      checks++;
      if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_valid cyc %0d: got %b want 0", c, ov1); end
    end
    tick;
    reset = 1'b0;
    #1;
    checks++;
    if (rd1 !== 1'b1) begin errors++; $display("FAIL first_read: got %b want 1", rd1); end
  endtask

  task automatic test_stream;
    for (int c = 1; c <= 7; c++) begin
      tick; #1;
      checks++;
      if (rd1 !== (c <= 4)) begin errors++; $display("FAIL stream_rd cyc %0d: got %b want %b", c, rd1, (c <= 4)); end
      checks++;
      if (ov1 !== (c >= 2 && c <= 6)) begin errors++; $display("FAIL stream_valid cyc %0d: got %b", c, ov1); end
      if (c >= 2 && c <= 6) begin
        checks++;
        if (od1 !== 4'(c - 1)) begin errors++; $display("FAIL stream_data cyc %0d: got %0d want %0d", c, od1, c - 1); end
      end
    end
  endtask

  task automatic test_backpressure;
    int pops;
    pops = 0;
    tick;
    reset = 1'b1; flush = 1'b1;
    tick;
    reset = 1'b0; flush = 1'b0; or1 = 1'b0;
    for (int v = 1; v <= 5; v++) push1(4'(v));
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin tick; #1; end
      if (rd1) pops++;
      if (c >= 2) begin
        checks++;
        if ({ov1, od1} !== {1'b1, 4'd1}) begin errors++; $display("FAIL bp_hold cyc %0d: got v=%b d=%0d want v=1 d=1", c, ov1, od1); end
      end
    end
    checks++;
    if (pops != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", pops); end
    tick;
    or1 = 1'b1;
    #1;
    for (int c = 10; c <= 15; c++) begin
      if (c > 10) begin tick; #1; end
      checks++;
      if (c <= 14) begin
        if ({ov1, od1} !== {1'b1, 4'(c - 9)}) begin errors++; $display("FAIL bp_drain cyc %0d: got v=%b d=%0d want d=%0d", c, ov1, od1, c - 9); end
      end else if (ov1 !== 1'b0) begin
        errors++; $display("FAIL bp_drain_end: got valid %b want 0", ov1);
      end
    end
  endtask

  task automatic test_empty;
    for (int c = 0; c < 8; c++) begin
      tick; #1;
      checks++;
      if (rd1 !== 1'b0) begin errors++; $display("FAIL empty_rd cyc %0d: got %b want 0", c, rd1); end
    end
    tick;
    push1(4'hA);
    #1;
    checks++;
    if (rd1 !== 1'b1) begin errors++; $display("FAIL empty_pop: got %b want 1", rd1); end
    tick; #1;
    checks++;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL empty_lat1: got valid %b want 0", ov1); end
    tick; #1;
    checks++;
    if ({ov1, od1} !== {1'b1, 4'hA}) begin errors++; $display("FAIL empty_lat2: got v=%b d=%h want v=1 d=a", ov1, od1); end
    tick; #1;
    checks++;
    if (ov1 !== 1'b0) begin errors++; $display("FAIL empty_after: got valid %b want 0", ov1); end
  endtask

  task automatic test_reset_midop;
    tick;
    or1 = 1'b0;
    push1(4'd7); push1(4'd8);
    #1;
    tick; #1;
    checks++;
    if (rd1 !== 1'b1) begin errors++; $display("FAIL mid_second_pop: got %b want 1", rd1); end
    tick;
    reset = 1'b1; flush = 1'b1;
    #1;
    checks++;
    if ({ov1, od1} !== {1'b1, 4'd7}) begin errors++; $display("FAIL mid_buffered: got v=%b d=%0d want v=1 d=7", ov1, od1); end
    checks++;
    if (rd1 !== 1'b0) begin errors++; $display("FAIL mid_rd_in_reset: got %b want 0", rd1); end
    tick;
    reset = 1'b0; flush = 1'b0; or1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (ov1 !== 1'b0) begin errors++; $display("FAIL mid_discard cyc %0d: got valid %b want 0", c, ov1); end
      tick;
    end
    push1(4'd9);
    #1;
    tick; tick; #1;
    checks++;
    if ({ov1, od1} !== {1'b1, 4'd9}) begin errors++; $display("FAIL mid_resume: got v=%b d=%0d want v=1 d=9", ov1, od1); end
  endtask

  task automatic test_rdlat2;
    tick;
    or2 = 1'b1;
    for (int v = 1; v <= 6; v++) push2(4'(v));
    #1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) begin tick; #1; end
      checks++;
      if (rd2 !== (c <= 5)) begin errors++; $display("FAIL lat2_rd cyc %0d: got %b want %b", c, rd2, (c <= 5)); end
      checks++;
      if (ov2 !== (c >= 3 && c <= 8)) begin errors++; $display("FAIL lat2_valid cyc %0d: got %b", c, ov2); end
      if (c >= 3 && c <= 8) begin
        checks++;
        if (od2 !== 4'(c - 2)) begin errors++; $display("FAIL lat2_data cyc %0d: got %0d want %0d", c, od2, c - 2); end
      end
    end
`ifdef FIFO_DRAIN_COUNT_EN
    checks++;
    if (wc2 !== 16'd6) begin errors++; $display("FAIL lat2_count: got %0d want 6", wc2); end
`endif
  endtask

  task automatic test_back_to_back_toggle;
    int got;
    got = 0;
    tick;
    for (int v = 7; v <= 12; v++) push2(4'(v));
    for (int c = 0; c < 40 && got < 6; c++) begin
      or2 = c[0];
      #1;
      if (ov2 && or2) begin
        checks++;
        if (od2 !== 4'(7 + got)) begin errors++; $display("FAIL toggle_data word %0d: got %0d want %0d", got, od2, 7 + got); end
        got++;
      end
      tick;
    end
    checks++;
    if (got != 6) begin errors++; $display("FAIL toggle_count: got %0d words want 6", got); end
`ifdef FIFO_DRAIN_COUNT_EN
    checks++;
    if (wc2 !== 16'd12) begin errors++; $display("FAIL toggle_wordcount: got %0d want 12", wc2); end
`endif
  endtask

  initial begin
    wp1 = 8'd0;
    wp2 = 8'd0;
    or1 = 1'b0;
    or2 = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_empty;
    test_reset_midop;
    test_rdlat2;
    test_back_to_back_toggle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
